// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, data first with a fetch starvation guard
module mem_port_arbiter #(
    parameter int AW           = 16,
    parameter int DW           = 16,
    parameter int STARVE_LIMIT = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_ack,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          stall_if,
    output logic          stall_dm
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, GNT_IF, GNT_DM, DONE} state_t;

    state_t        r_state, w_next;
    logic          r_win_dm;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [DW-1:0] r_wdata, r_if_rdata, r_dm_rdata;
    logic          w_arb, w_pick_if;

    assign w_arb     = (r_state == IDLE) && (if_req || dm_req);
    assign w_pick_if = if_req && (!dm_req || r_cnt == LIM);

    // next state: arbitrate in IDLE, wait for mem_ack in a grant, DONE always returns to IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:           if (if_req || dm_req) w_next = w_pick_if ? GNT_IF : GNT_DM;
            GNT_IF, GNT_DM: if (mem_ack) w_next = DONE;
            default:        w_next = IDLE;
        endcase
    end

    // state, starvation counter, winner's request fields and per-requester read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_win_dm   <= 1'b0;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_arb) begin
                r_win_dm <= !w_pick_if;
                r_addr   <= w_pick_if ? if_addr : dm_addr;
                r_we     <= !w_pick_if && dm_we;
                if (!w_pick_if) r_wdata <= dm_wdata;
                r_cnt    <= (w_pick_if || !if_req) ? '0 : (r_cnt == LIM ? LIM : r_cnt + 1'b1);
            end
            if (mem_ack && r_state == GNT_IF) r_if_rdata <= mem_rdata;
            if (mem_ack && r_state == GNT_DM) r_dm_rdata <= mem_rdata;
        end
    end

    assign mem_req   = (r_state == GNT_IF) || (r_state == GNT_DM);
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_ack    = (r_state == DONE) && !r_win_dm;
    assign dm_ack    = (r_state == DONE) && r_win_dm;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign stall_if  = if_req && !if_ack;
    assign stall_dm  = dm_req && !dm_ack;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus hand sequences for starvation and reset corner cases
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, dm_req, dm_we, mem_ack;
    logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic        if_ack, dm_ack, mem_req, mem_we, stall_if, stall_dm;
    logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(.AW(16), .DW(16), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_dm(stall_dm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ifr;
        logic [15:0] ifa;
        logic        dmr;
        logic        dmw;
        logic [15:0] dma;
        logic [15:0] dmd;
        logic [15:0] mrd;
        logic        mack;
        logic        mreq;
        logic        mwe;
        logic [15:0] maddr;
        logic [15:0] mwd;
        logic        iack;
        logic [15:0] ird;
        logic        dack;
        logic [15:0] drd;
        logic        sif;
        logic        sdm;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [69:0] outs();
        return {mem_req, mem_we, mem_addr, mem_wdata, if_ack, if_rdata, dm_ack, dm_rdata, stall_if, stall_dm};
    endfunction

    task automatic get_grants(input int n, output logic [15:0] seq);
        int got = 0;
        int cyc = 0;
        seq = '0;
        while (got < n && cyc < 10 * n) begin
            @(negedge clk);
            #1;
            cyc++;
            check("ack_exclusive", {if_ack, dm_ack} == 2'b11, 1'b0);
            if (if_ack || dm_ack) begin
                seq[got] = if_ack;
                got++;
            end
        end
        check("grant_timeout", got, n);
    endtask

    initial begin
        logic [15:0] seq;
        rst_n = 1'b0; if_req = 1'b1; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        #12;
        check("reset_values", outs(), {68'h0, 1'b1, 1'b0});
        @(negedge clk);
        rst_n = 1'b1; if_req = 1'b0;

        tbl[0]  = '{1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 16'hBEEF, 1,  0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 0};
        tbl[1]  = '{1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 16'hBEEF, 1,  1, 0, 16'h0010, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 0};
        tbl[2]  = '{1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 16'hBEEF, 1,  0, 0, 16'h0010, 16'h0000, 1, 16'hBEEF, 0, 16'h0000, 0, 0};
        tbl[3]  = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hBEEF, 1,  0, 0, 16'h0010, 16'h0000, 0, 16'hBEEF, 0, 16'h0000, 0, 0};
        tbl[4]  = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h1111, 1,  0, 0, 16'h0010, 16'h0000, 0, 16'hBEEF, 0, 16'h0000, 0, 0};
        tbl[5]  = '{0, 16'h0000, 1, 1, 16'h0200, 16'h1234, 16'h0000, 0,  0, 0, 16'h0010, 16'h0000, 0, 16'hBEEF, 0, 16'h0000, 0, 1};
        tbl[6]  = '{0, 16'h0000, 1, 1, 16'h0200, 16'h1234, 16'h0000, 0,  1, 1, 16'h0200, 16'h1234, 0, 16'hBEEF, 0, 16'h0000, 0, 1};
        tbl[7]  = '{0, 16'h0000, 1, 1, 16'h0200, 16'h1234, 16'h0000, 0,  1, 1, 16'h0200, 16'h1234, 0, 16'hBEEF, 0, 16'h0000, 0, 1};
        tbl[8]  = '{0, 16'h0000, 1, 1, 16'h0200, 16'h1234, 16'h0000, 0,  1, 1, 16'h0200, 16'h1234, 0, 16'hBEEF, 0, 16'h0000, 0, 1};
        tbl[9]  = '{0, 16'h0000, 1, 1, 16'h0200, 16'h1234, 16'h0000, 1,  1, 1, 16'h0200, 16'h1234, 0, 16'hBEEF, 0, 16'h0000, 0, 1};
        tbl[10] = '{0, 16'h0000, 1, 1, 16'h0200, 16'h1234, 16'h0000, 1,  0, 1, 16'h0200, 16'h1234, 0, 16'hBEEF, 1, 16'h0000, 0, 0};
        tbl[11] = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1,  0, 1, 16'h0200, 16'h1234, 0, 16'hBEEF, 0, 16'h0000, 0, 0};
        tbl[12] = '{0, 16'h0000, 1, 0, 16'h0300, 16'h0000, 16'h5A5A, 1,  0, 1, 16'h0200, 16'h1234, 0, 16'hBEEF, 0, 16'h0000, 0, 1};
        tbl[13] = '{0, 16'h0000, 1, 0, 16'h0300, 16'h0000, 16'h5A5A, 1,  1, 0, 16'h0300, 16'h0000, 0, 16'hBEEF, 0, 16'h0000, 0, 1};
        tbl[14] = '{0, 16'h0000, 1, 0, 16'h0300, 16'h0000, 16'h5A5A, 1,  0, 0, 16'h0300, 16'h0000, 0, 16'hBEEF, 1, 16'h5A5A, 0, 0};
        tbl[15] = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0,  0, 0, 16'h0300, 16'h0000, 0, 16'hBEEF, 0, 16'h5A5A, 0, 0};

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if_req = tbl[i].ifr; if_addr = tbl[i].ifa; dm_req = tbl[i].dmr; dm_we = tbl[i].dmw;
            dm_addr = tbl[i].dma; dm_wdata = tbl[i].dmd; mem_rdata = tbl[i].mrd; mem_ack = tbl[i].mack;
            #1;
            check($sformatf("vec%0d", i), outs(),
                  {tbl[i].mreq, tbl[i].mwe, tbl[i].maddr, tbl[i].mwd, tbl[i].iack, tbl[i].ird,
                   tbl[i].dack, tbl[i].drd, tbl[i].sif, tbl[i].sdm});
        end

        @(negedge clk);
        if_req = 1'b1; if_addr = 16'h1000; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h2000;
        mem_ack = 1'b1; mem_rdata = 16'hCAFE;
        get_grants(8, seq);
        check("starve_order", seq[7:0], 8'b1000_1000);
        get_grants(2, seq);
        check("pre_drop_dm", seq[1:0], 2'b00);
        if_req = 1'b0;
        get_grants(2, seq);
        check("if_low_dm", seq[1:0], 2'b00);
        if_req = 1'b1;
        get_grants(4, seq);
        check("count_from_zero", seq[3:0], 4'b1000);
        if_req = 1'b0; dm_req = 1'b0;

        @(negedge clk);
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0400; mem_ack = 1'b0; mem_rdata = 16'h7777;
        @(negedge clk);
        #1;
        check("rst_pre_grant", {mem_req, mem_addr}, {1'b1, 16'h0400});
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_drop", {mem_req, dm_ack, mem_addr}, {1'b0, 1'b0, 16'h0000});
        @(negedge clk);
        check("rst_held", {mem_req, dm_ack, stall_dm}, 3'b001);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rst_regrant", {mem_req, dm_ack, mem_addr}, {1'b1, 1'b0, 16'h0400});
        mem_ack = 1'b1;
        @(negedge clk);
        #1;
        check("rst_regrant_ack", {dm_ack, if_ack, dm_rdata}, {1'b1, 1'b0, 16'h7777});
        @(negedge clk);
        dm_req = 1'b0; mem_ack = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
